// File: rtl/reorder_buffer_pkg.sv
// Shared types and constants for the reorder buffer and its dispatch/retire neighbours.
package reorder_buffer_pkg;

  localparam int unsigned ROB_DEPTH = 16;
  localparam int unsigned ROB_PTR_W = 4;

  localparam logic [1:0] FU_ALU0 = 2'b00;
  localparam logic [1:0] FU_ALU1 = 2'b01;
  localparam logic [1:0] FU_MEM  = 2'b10;

  typedef struct packed {
    logic RegWrite;
    logic MemWrite;
    logic MemRead;
    logic Branch;
  } controlStruct;

  typedef struct packed {
    logic                 valid1;
    logic [ROB_PTR_W-1:0] robNum1;
    logic [31:0]          pc1;
    logic [5:0]           destReg1;
    logic [5:0]           destRegOld1;
    controlStruct         control1;
    logic                 valid2;
    logic [ROB_PTR_W-1:0] robNum2;
    logic [31:0]          pc2;
    logic [5:0]           destReg2;
    logic [5:0]           destRegOld2;
    controlStruct         control2;
  } robDispatchStruct;

  typedef struct packed {
    logic [31:0]  pc;
    logic [5:0]   destReg;
    logic [5:0]   destRegOld;
    controlStruct control;
  } robEntryStruct;

  typedef struct packed {
    logic         valid;
    logic [31:0]  pc;
    logic [5:0]   destReg;
    logic [5:0]   destRegOld;
    controlStruct control;
  } robRetireStruct;

endpackage

// File: rtl/reorder_buffer_if.sv
// Dispatch, completion and retire bundle between the core and the reorder buffer.
interface reorder_buffer_if
  import reorder_buffer_pkg::*;
#(
  parameter int unsigned NUM_CMPL = 3,
  parameter int unsigned PTR_W    = ROB_PTR_W
) ();

  robDispatchStruct                   robDispatch;
  logic [NUM_CMPL-1:0]                cmpl_valid;
  logic [NUM_CMPL-1:0][PTR_W-1:0]     cmpl_robNum;
  robRetireStruct [1:0]               retire;
  logic [1:0]                         free_valid;
  logic                               rob_full;
  logic                               rob_empty;
  logic                               rob_err;

  modport master (
    output robDispatch, cmpl_valid, cmpl_robNum,
    input  retire, free_valid, rob_full, rob_empty, rob_err
  );

  modport slave (
    input  robDispatch, cmpl_valid, cmpl_robNum,
    output retire, free_valid, rob_full, rob_empty, rob_err
  );

endinterface

// File: rtl/reorder_buffer_entry_array.sv
// ROB entry storage: payload registers plus per-entry valid/done tracking.
module reorder_buffer_entry_array
  import reorder_buffer_pkg::*;
#(
  parameter int unsigned DEPTH    = ROB_DEPTH,
  parameter int unsigned PTR_W    = ROB_PTR_W,
  parameter int unsigned NUM_CMPL = 3
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [1:0]                     wr_en,
  input  logic [1:0][PTR_W-1:0]          wr_idx,
  input  robEntryStruct [1:0]            wr_data,
  input  logic [NUM_CMPL-1:0]            cmpl_valid,
  input  logic [NUM_CMPL-1:0][PTR_W-1:0] cmpl_idx,
  input  logic [1:0]                     clr_en,
  input  logic [1:0][PTR_W-1:0]          clr_idx,
  input  logic [1:0][PTR_W-1:0]          rd_idx,
  output logic [DEPTH-1:0]               valid,
  output logic [DEPTH-1:0]               done,
  output robEntryStruct [1:0]            rd_data
);

  logic [DEPTH-1:0] valid_q, valid_d;
  logic [DEPTH-1:0] done_q, done_d;
  robEntryStruct    entry_q [DEPTH];

  // Later updates override earlier ones: completion, then retire clear, then dispatch write.
  always_comb begin
    valid_d = valid_q;
    done_d  = done_q;
    for (int i = 0; i < int'(NUM_CMPL); i++) begin
      if (cmpl_valid[i] && valid_q[cmpl_idx[i]]) done_d[cmpl_idx[i]] = 1'b1;
    end
    for (int i = 0; i < 2; i++) begin
      if (clr_en[i]) begin
        valid_d[clr_idx[i]] = 1'b0;
        done_d[clr_idx[i]]  = 1'b0;
      end
    end
    for (int i = 0; i < 2; i++) begin
      if (wr_en[i]) begin
        valid_d[wr_idx[i]] = 1'b1;
        done_d[wr_idx[i]]  = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= '0;
      done_q  <= '0;
    end else begin
      valid_q <= valid_d;
      done_q  <= done_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < 2; i++) begin
        if (wr_en[i]) entry_q[wr_idx[i]] <= wr_data[i];
      end
    end
  end

  always_comb begin
    valid = valid_q;
    done  = done_q;
    for (int i = 0; i < 2; i++) rd_data[i] = entry_q[rd_idx[i]];
  end

endmodule

// File: rtl/reorder_buffer.sv
// 2-wide in-order retirement buffer: head/tail pointers, retire selection and status flags.
module reorder_buffer
  import reorder_buffer_pkg::*;
#(
  parameter int unsigned DEPTH    = ROB_DEPTH,
  parameter int unsigned PTR_W    = ROB_PTR_W,
  parameter int unsigned NUM_CMPL = 3
) (
  input logic              clk,
  input logic              reset,
  reorder_buffer_if.slave  bus
);

  localparam logic [PTR_W:0] FullThresh = (PTR_W+1)'(DEPTH - 1);

  logic [PTR_W-1:0]    head_q, head_d, tail_q, tail_d;
  logic [PTR_W-1:0]    head1, tail1, slot2_idx;
  logic [PTR_W:0]      count_q, count_d, num_disp, num_ret;
  logic                rob_full_q, rob_empty_q, rob_err_q, err_d;
  logic [1:0]          fire;
  logic [DEPTH-1:0]    valid, done;
  robEntryStruct [1:0] wr_data, head_data;
  robDispatchStruct    disp;

  assign disp = bus.robDispatch;

  always_comb begin
    head1     = head_q + PTR_W'(1);
    tail1     = tail_q + PTR_W'(1);
    slot2_idx = disp.valid1 ? tail1 : tail_q;
    // Retire sees registered done only, so a same-cycle completion retires next cycle.
    fire[0]   = valid[head_q] & done[head_q];
    fire[1]   = fire[0] & valid[head1] & done[head1];
    num_disp  = (PTR_W+1)'(disp.valid1) + (PTR_W+1)'(disp.valid2);
    num_ret   = (PTR_W+1)'(fire[0]) + (PTR_W+1)'(fire[1]);
    head_d    = head_q + num_ret[PTR_W-1:0];
    tail_d    = tail_q + num_disp[PTR_W-1:0];
    count_d   = count_q + num_disp - num_ret;
    err_d     = rob_err_q;
    if (disp.valid1 && (disp.robNum1 != tail_q || valid[tail_q])) err_d = 1'b1;
    if (disp.valid2 && (disp.robNum2 != slot2_idx || valid[slot2_idx])) err_d = 1'b1;
    if ((disp.valid1 || disp.valid2) && rob_full_q) err_d = 1'b1;
    for (int i = 0; i < int'(NUM_CMPL); i++) begin
      if (bus.cmpl_valid[i] && !valid[bus.cmpl_robNum[i]]) err_d = 1'b1;
    end
  end

  always_comb begin
    wr_data[0] = '{pc: disp.pc1, destReg: disp.destReg1, destRegOld: disp.destRegOld1,
                   control: disp.control1};
    wr_data[1] = '{pc: disp.pc2, destReg: disp.destReg2, destRegOld: disp.destRegOld2,
                   control: disp.control2};
  end

  reorder_buffer_entry_array #(
    .DEPTH    (DEPTH),
    .PTR_W    (PTR_W),
    .NUM_CMPL (NUM_CMPL)
  ) u_entries (
    .clk        (clk),
    .reset      (reset),
    .wr_en      ({disp.valid2, disp.valid1}),
    .wr_idx     ({slot2_idx, tail_q}),
    .wr_data    (wr_data),
    .cmpl_valid (bus.cmpl_valid),
    .cmpl_idx   (bus.cmpl_robNum),
    .clr_en     (fire),
    .clr_idx    ({head1, head_q}),
    .rd_idx     ({head1, head_q}),
    .valid      (valid),
    .done       (done),
    .rd_data    (head_data)
  );

  always_comb begin
    for (int i = 0; i < 2; i++) begin
      bus.retire[i] = '0;
      if (fire[i]) begin
        bus.retire[i] = '{valid: 1'b1, pc: head_data[i].pc, destReg: head_data[i].destReg,
                          destRegOld: head_data[i].destRegOld,
                          control: head_data[i].control};
      end
      bus.free_valid[i] = bus.retire[i].valid & bus.retire[i].control.RegWrite &
                          ~bus.retire[i].control.MemWrite;
    end
    bus.rob_full  = rob_full_q;
    bus.rob_empty = rob_empty_q;
    bus.rob_err   = rob_err_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      head_q      <= '0;
      tail_q      <= '0;
      count_q     <= '0;
      rob_full_q  <= 1'b0;
      rob_empty_q <= 1'b1;
      rob_err_q   <= 1'b0;
    end else begin
      head_q      <= head_d;
      tail_q      <= tail_d;
      count_q     <= count_d;
      rob_full_q  <= (count_d >= FullThresh);
      rob_empty_q <= (count_d == '0);
      rob_err_q   <= err_d;
    end
  end

endmodule

// File: tb/tb_reorder_buffer.sv
// Reorder buffer bench: directed scenarios plus random traffic against a program-order queue model.
module tb_reorder_buffer;
  import reorder_buffer_pkg::*;

  localparam int unsigned NUM_CMPL = 3;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  reorder_buffer_if #(.NUM_CMPL(NUM_CMPL), .PTR_W(ROB_PTR_W)) bus ();

  reorder_buffer #(
    .DEPTH    (ROB_DEPTH),
    .PTR_W    (ROB_PTR_W),
    .NUM_CMPL (NUM_CMPL)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // In-flight instructions, oldest first, with the ROB slot each one occupies.
  typedef struct {
    int            idx;
    robEntryStruct e;
    bit            done;
  } rec_t;

  rec_t q[$];
  int   tail_m;
  bit   err_m, full_m, empty_m;
  int   total = 0, passed = 0, fails = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic bit in_q(input int idx);
    foreach (q[j]) if (q[j].idx == idx) return 1'b1;
    return 1'b0;
  endfunction

  function automatic int n_fire();
    if (q.size() == 0 || !q[0].done) return 0;
    if (q.size() < 2 || !q[1].done) return 1;
    return 2;
  endfunction

  function automatic robRetireStruct exp_ret(input int k, input int nf);
    robRetireStruct r = '0;
    if (k < nf) begin
      r.valid      = 1'b1;
      r.pc         = q[k].e.pc;
      r.destReg    = q[k].e.destReg;
      r.destRegOld = q[k].e.destRegOld;
      r.control    = q[k].e.control;
    end
    return r;
  endfunction

  function automatic robEntryStruct rand_entry();
    robEntryStruct e;
    e.pc         = $urandom;
    e.destReg    = 6'($urandom);
    e.destRegOld = 6'($urandom);
    e.control    = controlStruct'(4'($urandom));
    return e;
  endfunction

  task automatic set_disp(input int slot, input int rn, input robEntryStruct e);
    if (slot == 1) begin
      bus.robDispatch.valid1      = 1'b1;
      bus.robDispatch.robNum1     = 4'(rn);
      bus.robDispatch.pc1         = e.pc;
      bus.robDispatch.destReg1    = e.destReg;
      bus.robDispatch.destRegOld1 = e.destRegOld;
      bus.robDispatch.control1    = e.control;
    end else begin
      bus.robDispatch.valid2      = 1'b1;
      bus.robDispatch.robNum2     = 4'(rn);
      bus.robDispatch.pc2         = e.pc;
      bus.robDispatch.destReg2    = e.destReg;
      bus.robDispatch.destRegOld2 = e.destRegOld;
      bus.robDispatch.control2    = e.control;
    end
  endtask

  task automatic cmpl(input int port, input int rn);
    bus.cmpl_valid[port]  = 1'b1;
    bus.cmpl_robNum[port] = 4'(rn);
  endtask

  task automatic idle_inputs();
    bus.robDispatch = '0;
    bus.cmpl_valid  = '0;
    bus.cmpl_robNum = '0;
    reset           = 1'b0;
  endtask

  task automatic model_update(input robDispatchStruct d, input logic [NUM_CMPL-1:0] cv,
                              input logic [NUM_CMPL-1:0][3:0] cr, input bit rst, input int nf);
    int  exp1, exp2;
    bit  found;
    if (rst) begin
      q.delete();
      tail_m  = 0;
      err_m   = 1'b0;
      full_m  = 1'b0;
      empty_m = 1'b1;
      return;
    end
    exp1 = tail_m;
    exp2 = d.valid1 ? (tail_m + 1) % ROB_DEPTH : tail_m;
    if (d.valid1 && (int'(d.robNum1) != exp1 || in_q(exp1))) err_m = 1'b1;
    if (d.valid2 && (int'(d.robNum2) != exp2 || in_q(exp2))) err_m = 1'b1;
    if ((d.valid1 || d.valid2) && full_m) err_m = 1'b1;
    for (int p = 0; p < int'(NUM_CMPL); p++) begin
      if (cv[p]) begin
        found = 1'b0;
        foreach (q[j]) if (q[j].idx == int'(cr[p])) begin q[j].done = 1'b1; found = 1'b1; end
        if (!found) err_m = 1'b1;
      end
    end
    repeat (nf) void'(q.pop_front());
    if (d.valid1) q.push_back('{idx: exp1, done: 1'b0, e: '{pc: d.pc1, destReg: d.destReg1,
                               destRegOld: d.destRegOld1, control: d.control1}});
    if (d.valid2) q.push_back('{idx: exp2, done: 1'b0, e: '{pc: d.pc2, destReg: d.destReg2,
                               destRegOld: d.destRegOld2, control: d.control2}});
    tail_m  = (tail_m + int'(d.valid1) + int'(d.valid2)) % ROB_DEPTH;
    full_m  = q.size() >= ROB_DEPTH - 1;
    empty_m = q.size() == 0;
  endtask

  // Check outputs against the model, apply one clock edge, return at the next falling edge.
  task automatic cycle();
    robDispatchStruct               d;
    logic [NUM_CMPL-1:0]            cv;
    logic [NUM_CMPL-1:0][3:0]       cr;
    bit                             rst;
    int                             nf;
    robRetireStruct                 er;
    nf = n_fire();
    for (int k = 0; k < 2; k++) begin
      er = exp_ret(k, nf);
      chk($sformatf("retire%0d", k), 64'(bus.retire[k]), 64'(er));
      // A register is freed only by a retiring writer that is not a store.
      chk($sformatf("free_valid%0d", k), 64'(bus.free_valid[k]),
          64'(er.valid && er.control.RegWrite && !er.control.MemWrite));
    end
    chk("rob_full", 64'(bus.rob_full), 64'(full_m));
    chk("rob_empty", 64'(bus.rob_empty), 64'(empty_m));
    chk("rob_err", 64'(bus.rob_err), 64'(err_m));
    d   = bus.robDispatch;
    cv  = bus.cmpl_valid;
    cr  = bus.cmpl_robNum;
    rst = reset;
    @(posedge clk);
    model_update(d, cv, cr, rst, nf);
    @(negedge clk);
    idle_inputs();
  endtask

  robEntryStruct e;
  controlStruct  c;
  int            old_tag;
  bit            v1, v2;

  initial begin
    idle_inputs();
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    model_update('0, '0, '0, 1'b1, 0);

    // Reset held with dispatch and completion active: reset wins.
    reset = 1'b1;
    set_disp(1, 0, rand_entry());
    cmpl(int'(FU_ALU0), 0);
    cycle();
    repeat (2) cycle();

    // Pair 0/1; entry 1 completes first, both retire together once entry 0 is done.
    c = '{RegWrite: 1'b1, MemWrite: 1'b0, MemRead: 1'b0, Branch: 1'b0};
    set_disp(1, 0, '{pc: 32'h100, destReg: 6'd33, destRegOld: 6'd3, control: c});
    set_disp(2, 1, '{pc: 32'h104, destReg: 6'd34, destRegOld: 6'd4, control: c});
    cycle();
    cmpl(int'(FU_ALU1), 1);
    cycle();
    cmpl(int'(FU_ALU0), 0);
    cycle();
    chk("pair_free", 64'(bus.free_valid), 64'(2'b11));
    chk("pair_old0", 64'(bus.retire[0].destRegOld), 64'd3);
    chk("pair_old1", 64'(bus.retire[1].destRegOld), 64'd4);
    cycle();

    // Store pair: retires but frees nothing.
    c = '{RegWrite: 1'b1, MemWrite: 1'b1, MemRead: 1'b0, Branch: 1'b0};
    set_disp(1, 2, '{pc: 32'h200, destReg: 6'd40, destRegOld: 6'd7, control: c});
    set_disp(2, 3, '{pc: 32'h204, destReg: 6'd41, destRegOld: 6'd8, control: c});
    cycle();
    cmpl(int'(FU_MEM), 2);
    cmpl(int'(FU_ALU0), 3);
    cycle();
    chk("sw_retire", 64'(bus.retire[1].valid), 64'd1);
    chk("sw_free", 64'(bus.free_valid), 64'd0);
    cycle();

    // Fill with no completions until full; tail wraps past 15.
    for (int n = 0; n < 12 && !full_m; n++) begin
      set_disp(1, tail_m, rand_entry());
      set_disp(2, (tail_m + 1) % ROB_DEPTH, rand_entry());
      cycle();
    end
    chk("fill_full", 64'(bus.rob_full), 64'd1);
    cmpl(int'(FU_ALU0), q[0].idx);
    cmpl(int'(FU_ALU1), q[1].idx);
    cycle();
    cycle();
    chk("full_drop", 64'(bus.rob_full), 64'd0);

    // Random dispatch/completion traffic.
    for (int n = 0; n < 400; n++) begin
      if (!full_m && $urandom_range(0, 3) != 0) begin
        v1 = 1'($urandom_range(0, 1));
        v2 = 1'($urandom_range(0, 1));
        if (v1) set_disp(1, tail_m, rand_entry());
        if (v2) set_disp(2, v1 ? (tail_m + 1) % ROB_DEPTH : tail_m, rand_entry());
      end
      for (int p = 0; p < int'(NUM_CMPL); p++) begin
        if (q.size() > 0 && $urandom_range(0, 1) == 1)
          cmpl(p, q[$urandom_range(0, q.size() - 1)].idx);
      end
      cycle();
    end

    // Drain.
    for (int n = 0; n < 20; n++) begin
      for (int p = 0; p < int'(NUM_CMPL) && p < q.size(); p++) cmpl(p, q[p].idx);
      cycle();
    end
    chk("drain_empty", 64'(bus.rob_empty), 64'd1);

    // Completion to an invalid entry sets a sticky error.
    cmpl(int'(FU_ALU0), 5);
    cycle();
    chk("cmpl_invalid_err", 64'(bus.rob_err), 64'd1);
    repeat (2) cycle();

    // Mid-stream reset with six valid entries and completions in flight.
    for (int n = 0; n < 3; n++) begin
      set_disp(1, tail_m, rand_entry());
      set_disp(2, (tail_m + 1) % ROB_DEPTH, rand_entry());
      cycle();
    end
    old_tag = q[2].idx;
    cmpl(int'(FU_ALU0), q[0].idx);
    cmpl(int'(FU_MEM), q[1].idx);
    set_disp(1, tail_m, rand_entry());
    reset = 1'b1;
    cycle();
    chk("rst_empty", 64'(bus.rob_empty), 64'd1);
    chk("rst_err", 64'(bus.rob_err), 64'd0);
    cmpl(int'(FU_ALU1), old_tag);
    cycle();
    chk("stale_tag_err", 64'(bus.rob_err), 64'd1);

    // Wrong ROB number on dispatch.
    reset = 1'b1;
    cycle();
    set_disp(1, 3, rand_entry());
    cycle();
    chk("robnum_err", 64'(bus.rob_err), 64'd1);
    repeat (3) cycle();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
